dcache_ctrl: RTL

- Controller for the 2-way set-associative, write-back, write-allocate data cache.
- Sits between the CPU load/store port and two resources: the cache tag/data array (`cache`, one-cycle read latency) and the line-granular SDRAM controller (`sdram`).
- Sequences lookup, victim writeback, line fill and array update.
- On reset, clears all flag lines before it accepts any request.

---
 rtl/dcache_ctrl_pkg.sv | 47 ++++
 rtl/dcache_ctrl_if.sv | 50 +++++
 rtl/dcache_ctrl_hit_sel.sv | 39 +++
 rtl/dcache_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/dcache_ctrl_pkg.sv
// Shared types for the 2-way write-back data cache controller: address split,
// per-set flag line, data line and controller state encoding.
package dcache_ctrl_pkg;

    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned INDEX_W    = 7;
    localparam int unsigned TAG_W      = 16;
    localparam int unsigned OFFS_W     = 4;
    localparam int unsigned ADDR_W     = TAG_W + INDEX_W + OFFS_W;
    localparam int unsigned LINE_W     = 32 * LINE_WORDS;

    typedef logic [TAG_W-1:0]   tag_t;
    typedef logic [INDEX_W-1:0] index_t;
    typedef logic [LINE_W-1:0]  line_t;

    typedef struct packed {
        tag_t              tag;
        index_t            index;
        logic [OFFS_W-1:0] offset;
    } cache_addr_t;

    typedef struct packed {
        logic valid;
        logic dirty;
        tag_t tag;
    } way_flag_t;

    // lru names the way to evict next when both ways are valid
    typedef struct packed {
        logic            lru;
        way_flag_t [1:0] way;
    } flag_line_t;

    typedef line_t [1:0] data_line_t;

    typedef enum logic [2:0] {
        StInitClr,
        StWaitMem,
        StIdle,
        StCompare,
        StHitWr,
        StWriteback,
        StFill,
        StUpdate
    } dcache_state_t;

endpackage

// File: rtl/dcache_ctrl_if.sv
// Bundles the CPU port, cache-array port and SDRAM line port of the controller.
// slave is the controller's view, master the surrounding system's view.
interface dcache_ctrl_if;
    import dcache_ctrl_pkg::*;

    cache_addr_t addr;
    logic [31:0] data_in;
    logic        wr;
    logic        rd;
    logic        valid;
    logic [31:0] d_out;
    logic        done;

    logic        en_arr;
    index_t      index_arr;
    logic        rd_arr;
    logic        wr_arr;
    flag_line_t  flag_line_to_arr;
    data_line_t  data_line_to_arr;
    flag_line_t  flag_line_from_arr;
    data_line_t  data_line_from_arr;

    cache_addr_t mem_addr;
    logic        mem_wr;
    logic        mem_rd;
    logic        mem_valid;
    line_t       mem_line_out;
    line_t       mem_line_in;
    logic        mem_done;
    logic        mem_init_done;

    modport slave (
        input  addr, data_in, wr, rd, valid,
        output d_out, done,
        output en_arr, index_arr, rd_arr, wr_arr, flag_line_to_arr, data_line_to_arr,
        input  flag_line_from_arr, data_line_from_arr,
        output mem_addr, mem_wr, mem_rd, mem_valid, mem_line_out,
        input  mem_line_in, mem_done, mem_init_done
    );

    modport master (
        output addr, data_in, wr, rd, valid,
        input  d_out, done,
        input  en_arr, index_arr, rd_arr, wr_arr, flag_line_to_arr, data_line_to_arr,
        output flag_line_from_arr, data_line_from_arr,
        input  mem_addr, mem_wr, mem_rd, mem_valid, mem_line_out,
        output mem_line_in, mem_done, mem_init_done
    );

endinterface

// File: rtl/dcache_ctrl_hit_sel.sv
// Combinational tag compare, victim choice, word select and store-word merge.
module dcache_hit_sel
    import dcache_ctrl_pkg::*;
(
    input  flag_line_t  flags_i,
    input  tag_t        tag_i,
    input  data_line_t  lines_i,
    input  line_t       fill_i,
    input  logic        use_fill_i,
    input  logic [1:0]  word_sel_i,
    input  logic [31:0] wdata_i,
    output logic [1:0]  hit_o,
    output logic        hit_way_o,
    output logic        victim_o,
    output logic        victim_dirty_o,
    output logic [31:0] word_o,
    output line_t       merged_o
);

    line_t src_line;

    assign hit_o[0] = flags_i.way[0].valid && (flags_i.way[0].tag == tag_i);
    assign hit_o[1] = flags_i.way[1].valid && (flags_i.way[1].tag == tag_i);
    assign hit_way_o = hit_o[1];

    // Prefer an empty way (way0 first); fall back to the LRU pointer
    assign victim_o = !flags_i.way[0].valid ? 1'b0 :
                      !flags_i.way[1].valid ? 1'b1 : flags_i.lru;
    assign victim_dirty_o = flags_i.way[victim_o].valid && flags_i.way[victim_o].dirty;

    assign src_line = use_fill_i ? fill_i : lines_i[hit_way_o];
    assign word_o   = src_line[{word_sel_i, 5'b0} +: 32];

    always_comb begin
        merged_o = src_line;
        merged_o[{word_sel_i, 5'b0} +: 32] = wdata_i;
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Data cache controller: clears flags after reset, then sequences lookup,
// dirty-victim writeback, line fill and array update for CPU loads and stores.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
(
    input  logic         clk_50m,
    input  logic         rst_n,
    dcache_ctrl_if.slave bus
);

    dcache_state_t state_q, state_d;
    index_t        clr_cnt_q, clr_cnt_d;
    logic          clr_arm_q;
    tag_t          req_tag_q, req_tag_d;
    index_t        req_index_q, req_index_d;
    logic [1:0]    req_word_q, req_word_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          wr_q, wr_d;
    flag_line_t    flags_q, flags_d;
    data_line_t    lines_q, lines_d;
    logic          victim_q, victim_d;
    line_t         fill_q, fill_d;
    logic [31:0]   d_out_q, d_out_d;

    logic [1:0]  hit;
    logic        hit_way;
    logic        victim;
    logic        victim_dirty;
    logic [31:0] sel_word;
    line_t       merged;

    dcache_hit_sel u_hit_sel (
        .flags_i        (bus.flag_line_from_arr),
        .tag_i          (req_tag_q),
        .lines_i        (bus.data_line_from_arr),
        .fill_i         (fill_q),
        .use_fill_i     (state_q == StUpdate),
        .word_sel_i     (req_word_q),
        .wdata_i        (wdata_q),
        .hit_o          (hit),
        .hit_way_o      (hit_way),
        .victim_o       (victim),
        .victim_dirty_o (victim_dirty),
        .word_o         (sel_word),
        .merged_o       (merged)
    );

    assign bus.d_out = d_out_q;

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        req_tag_d   = req_tag_q;
        req_index_d = req_index_q;
        req_word_d  = req_word_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
        flags_d     = flags_q;
        lines_d     = lines_q;
        victim_d    = victim_q;
        fill_d      = fill_q;
        d_out_d     = d_out_q;

        bus.done             = 1'b0;
        bus.en_arr           = 1'b0;
        bus.rd_arr           = 1'b0;
        bus.wr_arr           = 1'b0;
        bus.index_arr        = '0;
        bus.flag_line_to_arr = '0;
        bus.data_line_to_arr = '0;
        bus.mem_addr         = '0;
        bus.mem_wr           = 1'b0;
        bus.mem_rd           = 1'b0;
        bus.mem_valid        = 1'b0;
        bus.mem_line_out     = '0;

        unique case (state_q)
            StInitClr: begin
                // clr_arm_q keeps all strobes low while reset is asserted
                if (clr_arm_q) begin
                    bus.en_arr    = 1'b1;
                    bus.wr_arr    = 1'b1;
                    bus.index_arr = clr_cnt_q;
                    clr_cnt_d     = clr_cnt_q + 1'b1;
                    if (clr_cnt_q == '1) state_d = StWaitMem;
                end
            end
            StWaitMem: begin
                if (bus.mem_init_done) state_d = StIdle;
            end
            StIdle: begin
                if (bus.valid && (bus.rd ^ bus.wr)) begin
                    req_tag_d     = bus.addr.tag;
                    req_index_d   = bus.addr.index;
                    req_word_d    = bus.addr.offset[3:2];
                    wdata_d       = bus.data_in;
                    wr_d          = bus.wr;
                    bus.en_arr    = 1'b1;
                    bus.rd_arr    = 1'b1;
                    bus.index_arr = bus.addr.index;
                    state_d       = StCompare;
                end
            end
            StCompare: begin
                flags_d = bus.flag_line_from_arr;
                lines_d = bus.data_line_from_arr;
                if (|hit) begin
                    flags_d.lru = ~hit_way;
                    if (wr_q) begin
                        flags_d.way[hit_way].dirty = 1'b1;
                        lines_d[hit_way]           = merged;
                    end else begin
                        d_out_d = sel_word;
                    end
                    state_d = StHitWr;
                end else begin
                    victim_d = victim;
                    state_d  = victim_dirty ? StWriteback : StFill;
                end
            end
            StHitWr: begin
                bus.en_arr           = 1'b1;
                bus.wr_arr           = 1'b1;
                bus.index_arr        = req_index_q;
                bus.flag_line_to_arr = flags_q;
                bus.data_line_to_arr = lines_q;
                bus.done             = 1'b1;
                state_d              = StIdle;
            end
            StWriteback: begin
                bus.mem_wr       = 1'b1;
                bus.mem_valid    = 1'b1;
                bus.mem_addr     = '{tag: flags_q.way[victim_q].tag, index: req_index_q,
                                     offset: '0};
                bus.mem_line_out = lines_q[victim_q];
                if (bus.mem_done) state_d = StFill;
            end
            StFill: begin
                bus.mem_rd    = 1'b1;
                bus.mem_valid = 1'b1;
                bus.mem_addr  = '{tag: req_tag_q, index: req_index_q, offset: '0};
                if (bus.mem_done) begin
                    fill_d = bus.mem_line_in;
                    if (!wr_q) d_out_d = bus.mem_line_in[{req_word_q, 5'b0} +: 32];
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                bus.en_arr           = 1'b1;
                bus.wr_arr           = 1'b1;
                bus.index_arr        = req_index_q;
                bus.flag_line_to_arr = flags_q;
                bus.flag_line_to_arr.way[victim_q] = '{valid: 1'b1, dirty: wr_q, tag: req_tag_q};
                bus.flag_line_to_arr.lru           = ~victim_q;
                bus.data_line_to_arr = lines_q;
                bus.data_line_to_arr[victim_q] = wr_q ? merged : fill_q;
                bus.done             = 1'b1;
                state_d              = StIdle;
            end
            default: state_d = StInitClr;
        endcase
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StInitClr;
            clr_cnt_q   <= '0;
            clr_arm_q   <= 1'b0;
            req_tag_q   <= '0;
            req_index_q <= '0;
            req_word_q  <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            flags_q     <= '0;
            lines_q     <= '0;
            victim_q    <= 1'b0;
            fill_q      <= '0;
            d_out_q     <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            clr_arm_q   <= 1'b1;
            req_tag_q   <= req_tag_d;
            req_index_q <= req_index_d;
            req_word_q  <= req_word_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            flags_q     <= flags_d;
            lines_q     <= lines_d;
            victim_q    <= victim_d;
            fill_q      <= fill_d;
            d_out_q     <= d_out_d;
        end
    end

endmodule
